// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command/register-access controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD
  } state_t;

  localparam int         CMD_RW_BIT        = 7;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchroniser for the raw chip select, with frame start/end pulses.
module spi_cs_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_raw,
  output logic frame_start,
  output logic frame_end
);

  logic       cs_meta;
  logic       cs_s;
  logic       cs_d;
  logic [1:0] settle;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
      cs_d    <= 1'b1;
      settle  <= 2'd0;
    end else begin
      cs_meta <= cs_raw;
      cs_s    <= cs_meta;
      cs_d    <= cs_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  // Edges are suppressed until every stage holds a real pin sample, so a reset
  // taken with CS already low never fabricates a frame start.
  assign frame_start = (settle == 2'd3) &&  cs_d && !cs_s;
  assign frame_end   = (settle == 2'd3) && !cs_d &&  cs_s;

endmodule

// File: rtl/spi_reg_controller.sv
// Command decoder and register-bank sequencer sitting behind spi_slave.
module spi_reg_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter int         AUTO_INC  = 1,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              system_clk,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_data_ready,
  input  logic [7:0]        spi_rx_data,
  output logic              spi_read_ack,
  output logic [7:0]        data_to_send,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wr_data,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  output logic              frame_err,
  output logic              Debug_ctrl
);

  logic   frame_start;
  logic   frame_end;
  logic   ack_d;
  logic   consume;
  state_t state;

  spi_cs_sync u_cs_sync (
    .clk         (system_clk),
    .reset_n     (reset_n),
    .cs_raw      (spi_cs),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  // The ready flag may linger through the ack cycle and the one after it while
  // spi_slave clears it; both are blocked so a byte is never taken twice.
  assign consume = spi_data_ready && !spi_read_ack && !ack_d;

  always_ff @(posedge system_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      spi_read_ack <= 1'b0;
      ack_d        <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_rd_en    <= 1'b0;
      reg_addr     <= '0;
      reg_wr_data  <= 8'h00;
      data_to_send <= IDLE_BYTE;
      frame_err    <= 1'b0;
      Debug_ctrl   <= 1'b0;
    end else begin
      spi_read_ack <= consume;
      ack_d        <= spi_read_ack;
      reg_wr_en    <= 1'b0;
      reg_rd_en    <= 1'b0;
      if (consume) Debug_ctrl <= !Debug_ctrl;
      if (reg_wr_en && AUTO_INC != 0) reg_addr <= reg_addr + ADDR_W'(1);

      case (state)
        IDLE: begin
          if (consume) frame_err <= 1'b1;
          if (frame_start) state <= CMD;
        end
        CMD: begin
          if (consume) begin
            reg_addr <= spi_rx_data[ADDR_W-1:0];
            if (frame_end) begin
              state <= IDLE;
            end else if (spi_rx_data[CMD_RW_BIT]) begin
              reg_rd_en <= 1'b1;
              state     <= RD_ISSUE;
            end else begin
              state <= WR;
            end
          end else if (frame_end) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        WR: begin
          if (consume) begin
            reg_wr_data <= spi_rx_data;
            reg_wr_en   <= 1'b1;
          end
          if (frame_end) begin
            data_to_send <= IDLE_BYTE;
            state        <= IDLE;
          end
        end
        RD_ISSUE: begin
          state <= frame_end ? IDLE : RD_CAPTURE;
        end
        RD_CAPTURE: begin
          data_to_send <= reg_rd_data;
          if (AUTO_INC != 0) reg_addr <= reg_addr + ADDR_W'(1);
          state <= frame_end ? IDLE : RD_HOLD;
        end
        RD_HOLD: begin
          if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Randomised self-checking bench for spi_reg_controller with a frame-level reference model.
module tb_spi_reg_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_data_ready = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic       spi_read_ack;
  logic [7:0] data_to_send;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data = 8'h00;
  logic       frame_err;
  logic       Debug_ctrl;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  int rd_cnt = 0;
  int overlap_cnt = 0;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] mem[128];
  logic [7:0] fq[$];
  logic       dbg_exp = 1'b0;

  spi_reg_controller dut (
    .system_clk     (clk),
    .reset_n        (reset_n),
    .spi_cs         (spi_cs),
    .spi_data_ready (spi_data_ready),
    .spi_rx_data    (spi_rx_data),
    .spi_read_ack   (spi_read_ack),
    .data_to_send   (data_to_send),
    .reg_addr       (reg_addr),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_data    (reg_wr_data),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data),
    .frame_err      (frame_err),
    .Debug_ctrl     (Debug_ctrl)
  );

  always #5 clk = ~clk;

  // Register bank: read data appears the cycle after the strobe.
  always @(posedge clk) if (reg_rd_en) reg_rd_data <= mem[reg_addr];

  always @(negedge clk) begin
    if (spi_read_ack) ack_cnt++;
    if (reg_rd_en) rd_cnt++;
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wr_data);
    end
    if (reg_wr_en && reg_rd_en) overlap_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dbg_exp = 1'b0;
  endtask

  // Emulates spi_slave: flag raised, cleared once the ack is seen.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    @(negedge clk); spi_rx_data = b; spi_data_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (spi_read_ack === 1'b1) got = 1'b1;
    end
    spi_data_ready = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: byte %02h actual=no ack required=ack within 20 cycles", b);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_frame();
    @(negedge clk); spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    foreach (fq[i]) send_byte(fq[i]);
    repeat (8) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    if (fq.size() % 2 == 1) dbg_exp = ~dbg_exp;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (spi_read_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: actual=%b required=0", spi_read_ack); end
    checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: actual=%b required=0", reg_wr_en); end
    checks++; if (reg_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: actual=%b required=0", reg_rd_en); end
    checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: actual=%02h required=00", reg_addr); end
    checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: actual=%02h required=00", reg_wr_data); end
    checks++; if (data_to_send !== 8'hA5) begin errors++; $display("FAIL reset_data_to_send: actual=%02h required=a5", data_to_send); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: actual=%b required=0", frame_err); end
    checks++; if (Debug_ctrl !== 1'b0) begin errors++; $display("FAIL reset_debug: actual=%b required=0", Debug_ctrl); end
  endtask

  // Write frame held in fq: expected writes derived from the command rules.
  task automatic test_write_frame(input string tag);
    int a0 = ack_cnt;
    int r0 = rd_cnt;
    int w0 = wr_addr_q.size();
    logic [6:0] a = fq[0][6:0];
    logic [6:0] ea[$];
    logic [7:0] ed[$];
    for (int i = 1; i < fq.size(); i++) begin
      ea.push_back(a);
      ed.push_back(fq[i]);
      a = a + 7'd1;
    end
    do_frame();
    checks++; if (ack_cnt - a0 != fq.size()) begin errors++; $display("FAIL %s_acks: actual=%0d required=%0d", tag, ack_cnt - a0, fq.size()); end
    checks++; if (wr_addr_q.size() - w0 != ed.size()) begin errors++; $display("FAIL %s_wr_count: actual=%0d required=%0d", tag, wr_addr_q.size() - w0, ed.size()); end
    if (wr_addr_q.size() - w0 == ed.size()) begin
      for (int i = 0; i < ed.size(); i++) begin
        checks++;
        if (wr_addr_q[w0+i] !== ea[i] || wr_data_q[w0+i] !== ed[i]) begin
          errors++;
          $display("FAIL %s_write%0d: actual=%02h@%02h required=%02h@%02h", tag, i, wr_data_q[w0+i], wr_addr_q[w0+i], ed[i], ea[i]);
        end
      end
    end
    checks++; if (rd_cnt != r0) begin errors++; $display("FAIL %s_no_read: actual=%0d required=%0d", tag, rd_cnt - r0, 0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL %s_frame_err: actual=%b required=0", tag, frame_err); end
    checks++; if (data_to_send !== 8'hA5) begin errors++; $display("FAIL %s_data_to_send: actual=%02h required=a5", tag, data_to_send); end
    checks++; if (reg_addr !== a) begin errors++; $display("FAIL %s_final_addr: actual=%02h required=%02h", tag, reg_addr, a); end
    checks++; if (Debug_ctrl !== dbg_exp) begin errors++; $display("FAIL %s_debug: actual=%b required=%b", tag, Debug_ctrl, dbg_exp); end
  endtask

  task automatic test_random_writes();
    for (int f = 0; f < 4; f++) begin
      int n = $urandom_range(1, 4);
      fq = {};
      fq.push_back(8'($urandom_range(0, 127)));
      for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
      test_write_frame($sformatf("rand_wr%0d", f));
    end
  endtask

  task automatic test_read(input logic [6:0] addr, input string tag);
    int a0 = ack_cnt;
    int r0 = rd_cnt;
    int w0 = wr_addr_q.size();
    logic [6:0] next_a = addr + 7'd1;
    fq = {8'h80 | {1'b0, addr}};
    do_frame();
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL %s_rd_count: actual=%0d required=1", tag, rd_cnt - r0); end
    checks++; if (data_to_send !== mem[addr]) begin errors++; $display("FAIL %s_data_to_send: actual=%02h required=%02h", tag, data_to_send, mem[addr]); end
    checks++; if (reg_addr !== next_a) begin errors++; $display("FAIL %s_addr: actual=%02h required=%02h", tag, reg_addr, next_a); end
    checks++; if (wr_addr_q.size() != w0) begin errors++; $display("FAIL %s_no_write: actual=%0d required=0", tag, wr_addr_q.size() - w0); end
    checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL %s_acks: actual=%0d required=1", tag, ack_cnt - a0); end
  endtask

  task automatic test_ready_held();
    int a0 = ack_cnt;
    int w0 = wr_addr_q.size();
    bit got = 1'b0;
    @(negedge clk); spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h40);
    @(negedge clk); spi_rx_data = 8'hC3; spi_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    spi_data_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ack_cnt - a0 != 2) begin errors++; $display("FAIL held_acks: actual=%0d required=2", ack_cnt - a0); end
    // Byte presented exactly in the cycle the frame-end pulse is high.
    spi_cs = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 spi_rx_data = 8'h5E; spi_data_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (spi_read_ack === 1'b1) got = 1'b1;
    end
    spi_data_ready = 1'b0;
    repeat (8) @(negedge clk);
    dbg_exp = ~dbg_exp;
    checks++; if (!got) begin errors++; $display("FAIL end_ack: actual=no ack required=ack"); end
    checks++; if (wr_addr_q.size() - w0 != 2) begin errors++; $display("FAIL held_wr_count: actual=%0d required=2", wr_addr_q.size() - w0); end
    if (wr_addr_q.size() - w0 == 2) begin
      checks++; if (wr_addr_q[w0] !== 7'h40 || wr_data_q[w0] !== 8'hC3) begin errors++; $display("FAIL held_write: actual=%02h@%02h required=c3@40", wr_data_q[w0], wr_addr_q[w0]); end
      checks++; if (wr_addr_q[w0+1] !== 7'h41 || wr_data_q[w0+1] !== 8'h5E) begin errors++; $display("FAIL end_write: actual=%02h@%02h required=5e@41", wr_data_q[w0+1], wr_addr_q[w0+1]); end
    end
    checks++; if (data_to_send !== 8'hA5) begin errors++; $display("FAIL end_data_to_send: actual=%02h required=a5", data_to_send); end
    checks++; if (reg_addr !== 7'h42) begin errors++; $display("FAIL end_addr: actual=%02h required=42", reg_addr); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL end_frame_err: actual=%b required=0", frame_err); end
    checks++; if (Debug_ctrl !== dbg_exp) begin errors++; $display("FAIL end_debug: actual=%b required=%b", Debug_ctrl, dbg_exp); end
  endtask

  task automatic test_empty_frame();
    int w0 = wr_addr_q.size();
    int r0 = rd_cnt;
    fq = {};
    do_frame();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL empty_frame_err: actual=%b required=1", frame_err); end
    checks++; if (wr_addr_q.size() != w0 || rd_cnt != r0) begin errors++; $display("FAIL empty_strobes: actual=%0d required=0", wr_addr_q.size() - w0 + rd_cnt - r0); end
    do_reset();
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL err_cleared: actual=%b required=0", frame_err); end
  endtask

  task automatic test_byte_outside();
    int a0 = ack_cnt;
    int w0 = wr_addr_q.size();
    send_byte(8'h5A);
    checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL outside_ack: actual=%0d required=1", ack_cnt - a0); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL outside_err: actual=%b required=1", frame_err); end
    checks++; if (wr_addr_q.size() != w0) begin errors++; $display("FAIL outside_no_write: actual=%0d required=0", wr_addr_q.size() - w0); end
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    int w0 = wr_addr_q.size();
    @(negedge clk); spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h10);
    send_byte(8'hAA);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL mid_reset_addr: actual=%02h required=00", reg_addr); end
    checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL mid_reset_wr_data: actual=%02h required=00", reg_wr_data); end
    checks++; if (data_to_send !== 8'hA5) begin errors++; $display("FAIL mid_reset_dts: actual=%02h required=a5", data_to_send); end
    checks++; if (Debug_ctrl !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: actual=%b%b required=00", Debug_ctrl, frame_err); end
    repeat (4) @(negedge clk);
    send_byte(8'hB1);
    send_byte(8'hB2);
    checks++; if (wr_addr_q.size() - w0 != 1) begin errors++; $display("FAIL mid_reset_no_write: actual=%0d required=1", wr_addr_q.size() - w0); end
    @(negedge clk); spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    fq = {8'h20, 8'h77};
    do_frame();
    checks++; if (wr_addr_q.size() - w0 != 2) begin errors++; $display("FAIL new_frame_count: actual=%0d required=2", wr_addr_q.size() - w0); end
    if (wr_addr_q.size() - w0 == 2) begin
      checks++; if (wr_addr_q[w0+1] !== 7'h20 || wr_data_q[w0+1] !== 8'h77) begin errors++; $display("FAIL new_frame_write: actual=%02h@%02h required=77@20", wr_data_q[w0+1], wr_addr_q[w0+1]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hA5) mem[i] = 8'h5A;
    end
    mem[5] = 8'h9D;
    test_reset();
    fq = {8'h05, 8'h3C};
    test_write_frame("single_wr");
    fq = {8'h7E, 8'h11, 8'h22, 8'h33};
    test_write_frame("burst_wrap");
    test_random_writes();
    test_read(7'h05, "read5");
    dbg_exp = ~dbg_exp;
    for (int k = 0; k < 3; k++) begin
      test_read(7'($urandom_range(0, 127)), $sformatf("rand_rd%0d", k));
      dbg_exp = ~dbg_exp;
    end
    test_ready_held();
    test_empty_frame();
    test_byte_outside();
    test_reset_mid_burst();
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap: actual=%0d required=0", overlap_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
Command/register-access sequencer that sits directly behind spi_slave in the top module. It consumes received bytes via the spi_data_ready/spi_read_ack handshake, decodes a command byte and then performs register writes or reads with address auto-increment. It drives the data_to_send byte for the next SPI frame. A simple register-bank interface is exposed to the rest of the design.

Parameters:
ADDR_W, 7, register address width; command byte is {rw, addr[6:0]}
AUTO_INC, 1, 1 = address increments after each data byte in a frame; 0 = address held
IDLE_BYTE, 8'hA5, value loaded into data_to_send after reset and after any write frame

Ports:
system_clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
spi_cs  in  1  raw SPI chip select (active low), same pin as spi_slave
spi_data_ready  in  1  byte-received flag from spi_slave
spi_rx_data  in  8  received byte from spi_slave
spi_read_ack  out  1  one-cycle pulse clearing spi_data_ready
data_to_send  out  8  byte spi_slave loads while CS is high, shifted out in the next frame
reg_addr  out  ADDR_W  register address
reg_wr_en  out  1  one-cycle write strobe
reg_wr_data  out  8  write data, valid with reg_wr_en
reg_rd_en  out  1  one-cycle read strobe
reg_rd_data  in  8  read data, valid the cycle after reg_rd_en
frame_err  out  1  sticky: frame ended in CMD state with zero bytes, or byte arrived outside a frame; cleared by reset
Debug_ctrl  out  1  toggles on every consumed byte

Behaviour:
- Reset values (reset_n low at a clock edge): state=IDLE, spi_read_ack=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wr_data=0, data_to_send=IDLE_BYTE, frame_err=0, Debug_ctrl=0, CS synchronisers=1.
- spi_cs goes through a 2-FF synchroniser to give cs_s. A frame starts on a cs_s 1->0 edge and ends on a cs_s 0->1 edge.
- Byte consume condition: spi_data_ready=1 and spi_read_ack registered value=0. On consume, assert spi_read_ack for exactly one cycle. The flag remains high during the ack cycle and is not consumed twice.
- States:
  - IDLE: frame start -> CMD. A consume in IDLE acks the byte, sets frame_err and discards the byte.
  - CMD: consume -> latch rw=rx[7] and reg_addr=rx[ADDR_W-1:0]. rw=0 -> WR. rw=1 -> RD_ISSUE. Frame end -> set frame_err, go to IDLE.
  - WR: each consume -> reg_wr_data=rx and reg_wr_en=1 for one cycle, at reg_addr. The address increments (mod 2^ADDR_W, wrapping 7F->00) the cycle after the strobe if AUTO_INC. Frame end -> IDLE, data_to_send=IDLE_BYTE.
  - RD_ISSUE: reg_rd_en=1 for one cycle -> RD_CAPTURE.
  - RD_CAPTURE: data_to_send=reg_rd_data, then the address increments if AUTO_INC -> RD_HOLD.
  - RD_HOLD: consumes are acked and ignored. Frame end -> IDLE, keeping data_to_send. The read value is shifted out during the next frame.
- Read latency: data_to_send is updated 2 cycles after the command-byte consume. It is only guaranteed to be transmitted if CS rises at least 4 system_clk cycles after the command byte completes.
- Frame end while spi_data_ready is pending: the byte is still consumed (acked) first using current-state semantics, then the frame-end transition is taken in the same cycle.
- reg_wr_en and reg_rd_en are never high together. Strobes are never issued outside a frame.
- reset_n low mid-frame: the controller returns to IDLE and ignores the rest of that frame (no strobes) until the next cs_s 1->0 edge.

Decomposition:
- Shared package spi_ctrl_pkg: state encoding constants (IDLE, CMD, WR, RD_ISSUE, RD_CAPTURE, RD_HOLD), CMD_RW_BIT=7, IDLE_BYTE default.
- One natural sub-module: spi_cs_sync (2-FF synchroniser plus start/end edge pulses, reset to 1). Everything else stays flat.

Test Plan:
- Frame bytes 0x05, 0x3C -> one reg_wr_en pulse with reg_addr=0x05 and reg_wr_data=0x3C. Exactly 2 spi_read_ack pulses; frame_err=0.
- Burst write 0x7E, 0x11, 0x22, 0x33 -> writes at 0x7E=0x11, 0x7F=0x22, 0x00=0x33 (wrap).
- Read: frame 0x85 with reg_rd_data=0x9D at addr 5 -> one reg_rd_en pulse; data_to_send=0x9D after CS high. The next frame shifts out 0x9D on MISO.
- Frame with CS low then high and no bytes -> frame_err=1, no strobes. Byte delivered while CS high -> acked, frame_err=1.
- spi_data_ready held high for 3 cycles -> exactly one ack and one consume. Consume coinciding with frame end -> byte processed, then IDLE.
- reset_n low for 1 cycle mid-burst write -> all outputs return to reset values; no further reg_wr_en until a new frame.
